div_seq: RTL and testbench

- Multi-cycle iterative divide/remainder unit for the execute stage; covers RV64M DIV/DIVU/REM/REMU and the W variants.
- Runs a radix-2 restoring shift-subtract sequence, one quotient bit per cycle, under a small FSM.
- Execute stalls on `busy`; the single-cycle ALU handles every other op.
- Handshake is valid/ready in, 1-cycle result pulse out; `flush` cancels.

---
 rtl/div_seq_pkg.sv | 26 ++
 rtl/div_seq_if.sv | 27 ++
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 160 ++++++++++++++++
 tb/tb_div_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared op encoding and FSM state type for the iterative divide unit.
package div_seq_pkg;

    localparam int DIV_XLEN = 64;

    // bit0 = unsigned, bit1 = remainder, bit2 = word (32-bit) op
    typedef enum logic [2:0] {
        DIV   = 3'b000,
        DIVU  = 3'b001,
        REM   = 3'b010,
        REMU  = 3'b011,
        DIVW  = 3'b100,
        DIVUW = 3'b101,
        REMW  = 3'b110,
        REMUW = 3'b111
    } divop_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the execute stage and the divide unit.
interface div_seq_if #(
    parameter int XLEN = 64
);
    import div_seq_pkg::*;

    logic            valid_in;
    logic            ready_out;
    divop_t          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            valid_out;
    logic [XLEN-1:0] c;

    modport master (
        output valid_in, op, a, b, flush,
        input  ready_out, busy, valid_out, c
    );

    modport slave (
        input  valid_in, op, a, b, flush,
        output ready_out, busy, valid_out, c
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic          fits;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        fits     = (shifted >= {1'b0, divisor});
        // After a successful subtract the result is below the divisor, so the top bit is zero.
        rem_next = fits ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divide/remainder unit for RV64M DIV/REM and W variants.
// state | meaning
// IDLE  | ready for a request
// PREP  | extend/abs operands, resolve divide-by-zero and signed overflow
// ITER  | one quotient bit per cycle, counter N-1 down to 0
// FIXUP | restore signs, select quotient or remainder, format W result
// DONE  | one-cycle valid_out pulse
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input logic      clk,
    input logic      reset,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    div_state_t      state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem, quo, divisor;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic [XLEN-1:0] c_q;
    logic [CW-1:0]   cnt;
    logic            sign_q, sign_r;
    logic            valid_q, ready_q, busy_q;

    logic            is_w, is_uns, sa, sb, div_zero, ovf;
    logic [XLEN-1:0] ax, bx, abs_a, abs_b, min_val, fq, fr;

    function automatic logic [XLEN-1:0] fmt_result(input logic [2:0] o,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] r);
        logic [XLEN-1:0] v;
        v = o[1] ? r : q;
        if (o[2]) v = {{(XLEN-32){v[31]}}, v[31:0]};
        return v;
    endfunction

    always_comb begin
        is_w   = op_q[2];
        is_uns = op_q[0];
        ax     = a_q;
        bx     = b_q;
        if (is_w) begin
            ax = is_uns ? {{(XLEN-32){1'b0}}, a_q[31:0]} : {{(XLEN-32){a_q[31]}}, a_q[31:0]};
            bx = is_uns ? {{(XLEN-32){1'b0}}, b_q[31:0]} : {{(XLEN-32){b_q[31]}}, b_q[31:0]};
        end
        sa       = !is_uns && ax[XLEN-1];
        sb       = !is_uns && bx[XLEN-1];
        abs_a    = sa ? -ax : ax;
        abs_b    = sb ? -bx : bx;
        min_val  = is_w ? {{(XLEN-32){1'b1}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (bx == '0);
        ovf      = !is_uns && (ax == min_val) && (bx == '1);
        fq       = sign_q ? -quo : quo;
        fr       = sign_r ? -rem : rem;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            c_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in && !bus.flush) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        state   <= PREP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                PREP: begin
                    if (bus.flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (div_zero || ovf) begin
                        // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
                        c_q     <= fmt_result(op_q, div_zero ? '1 : ax, div_zero ? ax : '0);
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        rem     <= '0;
                        quo     <= is_w ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                        divisor <= abs_b;
                        cnt     <= is_w ? CW'(31) : CW'(XLEN-1);
                        sign_q  <= sa ^ sb;
                        sign_r  <= sa;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    if (bus.flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        if (cnt == '0) state <= FIXUP;
                        else           cnt   <= cnt - CW'(1);
                    end
                end
                FIXUP: begin
                    if (bus.flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        c_q     <= fmt_result(op_q, fq, fr);
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.busy      = busy_q;
    assign bus.valid_out = valid_q;
    assign bus.c         = c_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, results, flush and reset behaviour.
module tb_div_seq;
    import div_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic vo_seen;

    div_seq_if #(.XLEN(64)) bus ();

    div_seq #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accept edge (cycle 0).
    task automatic run_op(input string tag, input divop_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_c, input int exp_lat);
        int          lat    = 0;
        logic [63:0] got    = '0;
        logic        hs_bad = 1'b0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.op       = divop_t'(~op);
        bus.a        = ~a;
        bus.b        = ~b;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (bus.ready_out !== 1'b0 || bus.busy !== 1'b1) hs_bad = 1'b1;
            if (bus.valid_out === 1'b1) begin
                lat = k;
                got = bus.c;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_c"}, got, exp_c);
        check({tag, "_busy_window"}, {63'b0, hs_bad}, 64'd0);
        @(negedge clk);
        check({tag, "_idle_after"}, {61'b0, bus.ready_out, bus.busy, bus.valid_out}, 64'b100);
        check({tag, "_c_held"}, bus.c, exp_c);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.op       = DIV;
        bus.a        = '0;
        bus.b        = '0;
        bus.flush    = 1'b0;
        #12;
        check("reset_c", bus.c, 64'd0);
        check("reset_flags", {61'b0, bus.ready_out, bus.busy, bus.valid_out}, 64'b100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("divu_100_7",   DIVU,  64'd100, 64'd7, 64'd14, 67);
        run_op("rem_m7_2",     REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run_op("div_m7_2",     DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
        run_op("div_100_m7",   DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 67);
        run_op("rem_100_m7",   REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 67);
        run_op("div_by_zero",  DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remu_by_zero", REMU,  64'd5, 64'd0, 64'd5, 2);
        run_op("div_ovf",      DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
        run_op("rem_ovf",      REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
        run_op("divw_ovf",     DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
        run_op("remw_ovf",     REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 2);
        run_op("divuw_max_1",  DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        run_op("remuw_hi_ign", REMUW, 64'h0000_0001_0000_0007, 64'h0000_0003_0000_0005, 64'd2, 35);
        run_op("divw_m7_2",    DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35);
        run_op("divuw_by_zero",DIVUW, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remw_by_zero", REMW,  64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2);
        run_op("remu_max_16",  REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 67);
        run_op("divu_max_3",   DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 67);

        // Flush during ITER: cancelled in cycle 20, idle in cycle 21, c keeps the last result.
        bus.op       = DIV;
        bus.a        = 64'd1000;
        bus.b        = 64'd10;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        vo_seen      = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) vo_seen = 1'b1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        if (bus.valid_out === 1'b1) vo_seen = 1'b1;
        check("flush_no_valid", {63'b0, vo_seen}, 64'd0);
        check("flush_idle_c21", {61'b0, bus.ready_out, bus.busy, bus.valid_out}, 64'b100);
        check("flush_c_kept", bus.c, 64'h5555_5555_5555_5555);
        run_op("after_flush", DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FF9C, 67);

        // Flush in IDLE blocks the accept.
        bus.op       = DIVU;
        bus.a        = 64'd9;
        bus.b        = 64'd3;
        bus.valid_in = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        check("idle_flush_no_accept", {61'b0, bus.ready_out, bus.busy, bus.valid_out}, 64'b100);

        // Async reset mid-ITER.
        bus.op       = DIV;
        bus.a        = 64'd77;
        bus.b        = 64'd3;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_c", bus.c, 64'd0);
        check("async_rst_flags", {61'b0, bus.ready_out, bus.busy, bus.valid_out}, 64'b100);
        @(negedge clk);
        reset   = 1'b1;
        vo_seen = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) vo_seen = 1'b1;
        end
        check("async_rst_no_valid", {63'b0, vo_seen}, 64'd0);
        run_op("after_reset", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
